// File: rtl/gcd_controller_if.sv
// Control bundle between the GCD sequencer and its datapath.
// The master side is the controller; the slave side is the datapath / requester.
interface gcd_controller_if;
  logic        start;
  logic        lt;
  logic        gt;
  logic        eq;
  logic        ldA;
  logic        ldB;
  logic        sel1;
  logic        sel2;
  logic        sel_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] iter_count;

  modport master (
    input  start, lt, gt, eq,
    output ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
  );

  modport slave (
    output start, lt, gt, eq,
    input  ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Moore sequencer for a subtract-and-compare GCD datapath with registered outputs.
// Optional feature: define GCD_TIMEOUT_EN to abort after MAX_ITER subtraction steps.
module gcd_controller #(
  parameter logic [15:0] MAX_ITER = 16'd1000
) (
  input logic               clk,
  input logic               rst_n,
  gcd_controller_if.master  ctl
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    SUB_A,
    SUB_B,
    DONE
  } state_t;

  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic sel1;
    logic sel2;
    logic sel_in;
    logic busy;
    logic done;
  } ctl_t;

  state_t      state_q;
  state_t      state_nxt;
  ctl_t        outs_q;
  logic        err_q;
  logic        err_nxt;
  logic [15:0] iter_q;
  logic        timeout_hit;

`ifdef GCD_TIMEOUT_EN
  assign timeout_hit = (iter_q >= MAX_ITER);
`else
  // No step limit in this build; the term below is constant zero.
  assign timeout_hit = 1'b0 && (iter_q >= MAX_ITER);
`endif

  // Output pattern for a given state; outputs are registered against the
  // state being entered so they line up exactly with state_q.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      LOAD_A: begin c.ld_a = 1'b1; c.sel_in = 1'b1; c.busy = 1'b1; end
      LOAD_B: begin c.ld_b = 1'b1; c.sel_in = 1'b1; c.busy = 1'b1; end
      CMP:    c.busy = 1'b1;
      SUB_A:  begin c.ld_a = 1'b1; c.sel2 = 1'b1; c.busy = 1'b1; end
      SUB_B:  begin c.ld_b = 1'b1; c.sel1 = 1'b1; c.busy = 1'b1; end
      DONE:   c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state_q;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE:   if (ctl.start) state_nxt = LOAD_A;
      LOAD_A: state_nxt = LOAD_B;
      LOAD_B: state_nxt = CMP;
      CMP: begin
        if (ctl.eq) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (ctl.gt) begin
          state_nxt = SUB_A;
        end else if (ctl.lt) begin
          state_nxt = SUB_B;
        end else begin
          // Comparator gave no answer: finish with an error rather than hang.
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
      SUB_A:   state_nxt = CMP;
      SUB_B:   state_nxt = CMP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state and output flops use an asynchronous reset so the
  // controls drop to 0 the moment rst_n falls, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      outs_q  <= '0;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_nxt;
      outs_q  <= decode(state_nxt);
      err_q   <= err_nxt;
      if (state_nxt == LOAD_B) begin
        iter_q <= '0;
      end else if ((state_nxt == SUB_A || state_nxt == SUB_B) && iter_q != 16'hFFFF) begin
        iter_q <= iter_q + 16'd1;
      end
    end
  end

  assign ctl.ldA        = outs_q.ld_a;
  assign ctl.ldB        = outs_q.ld_b;
  assign ctl.sel1       = outs_q.sel1;
  assign ctl.sel2       = outs_q.sel2;
  assign ctl.sel_in     = outs_q.sel_in;
  assign ctl.busy       = outs_q.busy;
  assign ctl.done       = outs_q.done;
  assign ctl.err        = err_q;
  assign ctl.iter_count = iter_q;

endmodule
